// File: rtl/duck_pkg.sv
// Shared constants and types for the duck sprite server: sheet geometry,
// transparent palette index, load FSM states, colour struct and the palette.
package duck_pkg;

  localparam int SPRITE_W = 320;                // 5 frames x 64 pixels
  localparam int SPRITE_H = 128;                // two facings x 64 rows
  localparam int DEPTH    = SPRITE_W * SPRITE_H; // pixel count
  localparam int WORDS    = DEPTH / 2;          // two pixels per RAM byte
  localparam int WORD_AW  = 15;                 // RAM word address width

  localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Entry 0 is never drawn (transparent); entry 1 is the black outline.
  localparam rgb_t PALETTE [16] = '{
    '{8'h00, 8'h00, 8'h00},
    '{8'h00, 8'h00, 8'h00},
    '{8'hF8, 8'hF8, 8'hF8},
    '{8'hBC, 8'hBC, 8'hBC},
    '{8'h7C, 8'h7C, 8'h7C},
    '{8'h3C, 8'hBC, 8'hFC},
    '{8'h00, 8'h78, 8'hF8},
    '{8'hF8, 8'hB8, 8'h00},
    '{8'hF8, 8'h78, 8'h58},
    '{8'h00, 8'hA8, 8'h00},
    '{8'hB8, 8'hF8, 8'h18},
    '{8'hF8, 8'h38, 8'h00},
    '{8'hA4, 8'hE4, 8'hFC},
    '{8'h88, 8'h14, 8'h00},
    '{8'hD8, 8'hF8, 8'h78},
    '{8'hFC, 8'hE0, 8'hA8}
  };

endpackage

// File: rtl/sprite_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Read of a word written in the same cycle returns the old contents.
module sprite_ram #(
  parameter int DEPTH = 20480,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port.
  always_ff @(posedge Clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/duck_sprite_server.sv
// Duck sprite server: loads the packed 4-bit sprite sheet from a byte stream,
// then returns the palette colour for every duck_addr with 2-cycle latency.
//
// Load handshake: a byte transfers on a rising edge where ld_valid && ld_ready
// are both high. ld_ready is high exactly while the FSM is in LOAD and does
// not depend on ld_valid; the source may raise or drop ld_valid freely.
module duck_sprite_server
  import duck_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        load_start,
  input  logic [7:0]  ld_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  output logic        load_done,
  input  logic [15:0] duck_addr,
  input  logic        is_duck,
  output logic        duck_visible,
  output logic [7:0]  duck_red,
  output logic [7:0]  duck_green,
  output logic [7:0]  duck_blue,
  output state_t      state_dbg
);

  state_t              state, state_next;
  logic [WORD_AW-1:0]  wr_ptr;
  logic                accept;
  logic                in_range;
  logic [WORD_AW-1:0]  rd_word;
  logic [7:0]          rd_data;
  logic                s1_nib, s1_hit;
  logic [3:0]          s1_idx;
  logic                s2_vis;
  logic [3:0]          s2_idx;
  rgb_t                pix;

  assign accept    = ld_valid && ld_ready;
  assign in_range  = duck_addr < 16'(DEPTH);
  // Out-of-range addresses read word 0; the hit bit masks the result anyway.
  assign rd_word   = in_range ? duck_addr[15:1] : '0;
  assign state_dbg = state;

  // Load FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and handshake/status outputs.
  always_comb begin
    state_next = state;
    ld_ready   = 1'b0;
    load_done  = 1'b0;
    case (state)
      IDLE: if (load_start) state_next = LOAD;
      LOAD: begin
        ld_ready = 1'b1;
        // The terminal beat wins over any load_start in the same cycle.
        if (ld_valid && wr_ptr == WORD_AW'(WORDS - 1)) state_next = DONE;
      end
      DONE: begin
        load_done = 1'b1;
        if (load_start) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  // Write pointer: cleared on entry to LOAD, advanced per accepted byte.
  always_ff @(posedge Clk) begin
    if (Reset)                                   wr_ptr <= '0;
    else if (state != LOAD && state_next == LOAD) wr_ptr <= '0;
    else if (accept)                             wr_ptr <= wr_ptr + 1'b1;
  end

  sprite_ram #(.DEPTH(WORDS), .WIDTH(8), .AW(WORD_AW)) u_ram (
    .Clk   (Clk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (ld_data),
    .raddr (rd_word),
    .rdata (rd_data)
  );

  assign s1_idx = s1_nib ? rd_data[7:4] : rd_data[3:0];

  // Read pipeline: S0 samples address/gating, S1 picks nibble and visibility.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_nib <= 1'b0;
      s1_hit <= 1'b0;
      s2_vis <= 1'b0;
      s2_idx <= '0;
    end else begin
      s1_nib <= duck_addr[0];
      s1_hit <= is_duck && load_done && in_range;
      s2_vis <= s1_hit && (s1_idx != TRANSPARENT_IDX);
      s2_idx <= s1_idx;
    end
  end

  // Palette stage: colour only when the pixel is drawn, black otherwise.
  always_comb begin
    pix = '0;
    if (s2_vis) pix = PALETTE[s2_idx];
  end

  assign duck_visible = s2_vis;
  assign duck_red     = pix.r;
  assign duck_green   = pix.g;
  assign duck_blue    = pix.b;

endmodule

// File: tb/tb_duck_sprite_server.sv
// Bench for duck_sprite_server: loads sheets through the byte stream and
// checks pixel reads against a byte-level memory model and palette table.
module tb_duck_sprite_server;
  import duck_pkg::*;

  localparam int NWORDS = 20480;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        load_start = 1'b0;
  logic [7:0]  ld_data = 8'h00;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic        load_done;
  logic [15:0] duck_addr = 16'h0000;
  logic        is_duck = 1'b0;
  logic        duck_visible;
  logic [7:0]  duck_red, duck_green, duck_blue;
  state_t      state_dbg;

  int total = 0;
  int bad   = 0;

  logic [7:0]  model_mem [NWORDS];
  logic [23:0] tb_pal [16] = '{
    24'h000000, 24'h000000, 24'hF8F8F8, 24'hBCBCBC,
    24'h7C7C7C, 24'h3CBCFC, 24'h0078F8, 24'hF8B800,
    24'hF87858, 24'h00A800, 24'hB8F818, 24'hF83800,
    24'hA4E4FC, 24'h881400, 24'hD8F878, 24'hFCE0A8
  };
  bit          tb_loaded = 1'b0;

  logic [24:0] exp_q [$];
  logic [15:0] rd_addr_q [$];
  logic        rd_isd_q [$];

  duck_sprite_server dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .load_start   (load_start),
    .ld_data      (ld_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .load_done    (load_done),
    .duck_addr    (duck_addr),
    .is_duck      (is_duck),
    .duck_visible (duck_visible),
    .duck_red     (duck_red),
    .duck_green   (duck_green),
    .duck_blue    (duck_blue),
    .state_dbg    (state_dbg)
  );

  // 50 MHz clock.
  always #10 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] model_pix(input logic [15:0] a, input logic isd);
    logic [7:0] b;
    logic [3:0] idx;
    if (!isd || !tb_loaded || a >= 16'hA000) return '0;
    b   = model_mem[a[15:1]];
    idx = a[0] ? b[7:4] : b[3:0];
    if (idx == 4'h0) return '0;
    return {1'b1, tb_pal[idx]};
  endfunction

  task automatic queue_read(input logic [15:0] a, input logic isd);
    rd_addr_q.push_back(a);
    rd_isd_q.push_back(isd);
  endtask

  // Streams all queued reads back to back; each output is compared exactly
  // two clock edges after its address was presented.
  task automatic run_reads();
    int n;
    logic [15:0] tags [$];
    logic [24:0] e;
    logic [15:0] t;
    n = rd_addr_q.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge Clk);
      if (i >= 2) begin
        e = exp_q.pop_front();
        t = tags.pop_front();
        check($sformatf("pix@%0h", t),
              {7'd0, duck_visible, duck_red, duck_green, duck_blue}, {7'd0, e});
      end
      if (i < n) begin
        duck_addr = rd_addr_q.pop_front();
        is_duck   = rd_isd_q.pop_front();
        exp_q.push_back(model_pix(duck_addr, is_duck));
        tags.push_back(duck_addr);
      end else begin
        duck_addr = 16'h0000;
        is_duck   = 1'b0;
      end
    end
  endtask

  // Drives one sheet load. pattern=1 uses the counting pattern, else random
  // bytes. pulse_at: byte index at which load_start is pulsed with a beat.
  // abort_at: byte index at which Reset is asserted instead (-1 = never).
  task automatic load_sheet(input int pct, input bit pattern, input int pulse_at, input int abort_at);
    int k;
    int cyc;
    bit pulse_done;
    logic [7:0] b;
    logic [3:0] lo, hi;
    k = 0;
    cyc = 0;
    pulse_done = 1'b0;
    @(negedge Clk);
    load_start = 1'b1;
    @(negedge Clk);
    load_start = 1'b0;
    tb_loaded = 1'b0;
    check("ld_ready_enter_load", 32'(ld_ready), 32'd1);
    check("load_done_enter_load", 32'(load_done), 32'd0);
    while (k < NWORDS && cyc < 60000) begin
      if (k == abort_at) begin
        ld_valid = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        check("abort_state", 32'(state_dbg), 32'(IDLE));
        check("abort_load_done", 32'(load_done), 32'd0);
        check("abort_ld_ready", 32'(ld_ready), 32'd0);
        Reset = 1'b0;
        return;
      end
      lo = k[3:0];
      hi = lo + 4'd1;
      b = pattern ? {hi, lo} : 8'($urandom);
      ld_valid = ($urandom_range(99) < pct);
      ld_data = b;
      if (k == pulse_at && !pulse_done && ld_valid) begin
        load_start = 1'b1;
        pulse_done = 1'b1;
      end else begin
        load_start = 1'b0;
      end
      if (ld_valid && ld_ready) begin
        model_mem[k] = b;
        if (k == NWORDS - 1) check("done_before_last", 32'(load_done), 32'd0);
        k++;
      end
      @(negedge Clk);
      cyc++;
    end
    ld_valid = 1'b0;
    load_start = 1'b0;
    if (k < NWORDS) begin
      check("load_timeout", 32'(k), 32'(NWORDS));
    end else begin
      check("load_done_rise", 32'(load_done), 32'd1);
      check("ld_ready_after_done", 32'(ld_ready), 32'd0);
      check("state_done", 32'(state_dbg), 32'(DONE));
      tb_loaded = 1'b1;
    end
  endtask

  initial begin
    logic [15:0] base;
    for (int i = 0; i < NWORDS; i++) model_mem[i] = 8'h00;

    // Reset and idle behaviour.
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_visible", 32'(duck_visible), 32'd0);
    check("rst_rgb", {8'd0, duck_red, duck_green, duck_blue}, 32'd0);
    for (int i = 0; i < 10; i++) queue_read(16'($urandom_range(40959)), 1'b1);
    run_reads();
    check("idle_ld_ready", 32'(ld_ready), 32'd0);
    check("idle_load_done", 32'(load_done), 32'd0);

    // Full-rate load of the counting pattern with a stray load_start mid-load.
    load_sheet(100, 1'b1, 5000, -1);
    queue_read(16'd2, 1'b1);
    queue_read(16'd3, 1'b1);
    queue_read(16'd0, 1'b1);
    queue_read(16'd1, 1'b1);
    queue_read(16'd3, 1'b0);
    queue_read(16'hA000, 1'b1);
    queue_read(16'hFFFF, 1'b1);
    queue_read(16'h9FFE, 1'b1);
    queue_read(16'h9FFF, 1'b1);
    queue_read(16'd9, 1'b1);
    base = 16'(70 * 320 + 64);
    for (int j = 0; j < 64; j++) queue_read(base + 16'(j), 1'b1);
    run_reads();

    // Reset in the middle of a load.
    load_sheet(100, 1'b0, -1, 1000);

    // Reload with 50% valid; load_start coincides with the terminal beat.
    load_sheet(50, 1'b0, NWORDS - 1, -1);
    base = 16'($urandom_range(127) * 320 + $urandom_range(4) * 64);
    for (int j = 0; j < 64; j++) queue_read(base + 16'(j), 1'b1);
    for (int j = 0; j < 40; j++) queue_read(16'($urandom_range(40959)), 1'($urandom_range(1)));
    for (int j = 0; j < 4; j++) queue_read(16'($urandom_range(65535, 40960)), 1'b1);
    run_reads();

    // Restart from DONE: load_done must drop one cycle later.
    @(negedge Clk);
    load_start = 1'b1;
    @(negedge Clk);
    load_start = 1'b0;
    tb_loaded = 1'b0;
    check("restart_load_done", 32'(load_done), 32'd0);
    check("restart_ld_ready", 32'(ld_ready), 32'd1);
    check("restart_state", 32'(state_dbg), 32'(LOAD));
    for (int j = 0; j < 8; j++) queue_read(16'($urandom_range(40959)), 1'b1);
    run_reads();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
